// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory fetch handshake between the IF stage and imem.
//   req   : fetch request, held high until ack
//   addr  : word fetch address, stable while req is high
//   ack   : response valid this cycle
//   rdata : instruction word, valid with ack
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end of the MIPS32 pipeline. Owns the PC, issues
// word fetches over a req/ack handshake and presents the IF-side signals to
// the IF/ID register, honouring ID backpressure and late-stage redirects.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ID_stall        : ID cannot accept, hold the presented instruction
//   redirect_valid  : one-cycle pulse, next fetch comes from redirect_pc
//   redirect_pc     : redirect target
//   imem            : fetch handshake (master side)
//   IF_inst         : instruction to IF/ID, 0 while IF_stall=1
//   IF_PC/IF_PCnext : address of IF_inst and that address + 4
//   IF_stall        : 1 = no valid instruction this cycle
//   IF_adel         : misaligned-fetch flag (only with IF_ALIGN_CHK_EN)
//
// Build option: define IF_ALIGN_CHK_EN to suppress fetches from misaligned
// PCs and report them on IF_adel instead.
//
// state | meaning
// ------+-----------------------------------------------------------------
// REQ   | requesting pc; delivers the response in the ack cycle
// HOLD  | delivered word held for ID; no request outstanding
// DROP  | completing a request whose data is stale; then fetch pend_pc
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ID_stall,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    if_fetch_unit_if.master         imem,
    output logic [31:0]             IF_inst,
    output logic [31:0]             IF_PC,
    output logic [31:0]             IF_PCnext,
`ifdef IF_ALIGN_CHK_EN
    output logic                    IF_adel,
`endif
    output logic                    IF_stall
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic        req_c;
    logic        stall_c;
    logic [31:0] inst_c;
    logic [31:0] if_pc_c;
    logic        misalign;
    logic        deliver;
    logic [31:0] deliver_inst;

`ifdef IF_ALIGN_CHK_EN
    logic hold_adel_q, hold_adel_d;
    logic adel_c;
    assign misalign = (pc_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned PC behaves like a zero-latency fetch returning 0.
    assign deliver      = misalign | imem.ack;
    assign deliver_inst = misalign ? 32'h0 : imem.rdata;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        hold_inst_d = hold_inst_q;
        req_c       = 1'b0;
        stall_c     = 1'b1;
        inst_c      = 32'h0;
        if_pc_c     = pc_q;
`ifdef IF_ALIGN_CHK_EN
        hold_adel_d = hold_adel_q;
        adel_c      = 1'b0;
`endif

        case (state_q)
            S_REQ: begin
                req_c = ~misalign;
                if (redirect_valid) begin
                    if (deliver) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Address must not move while req is high, so finish
                        // the handshake first and discard its data.
                        pend_pc_d = redirect_pc;
                        state_d   = S_DROP;
                    end
                end else if (deliver) begin
                    stall_c = 1'b0;
                    inst_c  = deliver_inst;
`ifdef IF_ALIGN_CHK_EN
                    adel_c  = misalign;
`endif
                    if (ID_stall) begin
                        hold_inst_d = deliver_inst;
`ifdef IF_ALIGN_CHK_EN
                        hold_adel_d = misalign;
`endif
                        state_d     = S_HOLD;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else begin
                    stall_c = 1'b0;
                    inst_c  = hold_inst_q;
`ifdef IF_ALIGN_CHK_EN
                    adel_c  = hold_adel_q;
`endif
                    if (!ID_stall) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
            end
            S_DROP: begin
                req_c = 1'b1;
                if (redirect_valid) begin
                    pend_pc_d = redirect_pc;
                end
                if (imem.ack) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // During reset the memory has dropped its request too; present a bubble.
        if (rst) begin
            req_c   = 1'b0;
            stall_c = 1'b1;
            inst_c  = 32'h0;
            if_pc_c = RESET_PC;
`ifdef IF_ALIGN_CHK_EN
            adel_c  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            pend_pc_q   <= RESET_PC;
            hold_inst_q <= 32'h0;
`ifdef IF_ALIGN_CHK_EN
            hold_adel_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            hold_inst_q <= hold_inst_d;
`ifdef IF_ALIGN_CHK_EN
            hold_adel_q <= hold_adel_d;
`endif
        end
    end

    assign imem.req  = req_c;
    assign imem.addr = pc_q;
    assign IF_stall  = stall_c;
    assign IF_inst   = inst_c;
    assign IF_PC     = if_pc_c;
    assign IF_PCnext = if_pc_c + 32'd4;
`ifdef IF_ALIGN_CHK_EN
    assign IF_adel   = adel_c;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] IF_inst, IF_PC, IF_PCnext;
    logic        IF_stall;
`ifdef IF_ALIGN_CHK_EN
    logic        IF_adel;
`endif

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(32'hBFC00000)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_stall       (ID_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem.master),
        .IF_inst        (IF_inst),
        .IF_PC          (IF_PC),
        .IF_PCnext      (IF_PCnext),
`ifdef IF_ALIGN_CHK_EN
        .IF_adel        (IF_adel),
`endif
        .IF_stall       (IF_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: ack after 'lat' waiting cycles; lat=0 acks in the req cycle.
    int unsigned lat = 0;
    int unsigned wait_cnt = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A55A5A;
    endfunction

    always_comb begin
        imem.ack   = imem.req && (wait_cnt == lat);
        imem.rdata = imem.ack ? mem_f(imem.addr) : 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (rst || !imem.req || imem.ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pcnext;
        logic        adel;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input logic [31:0] pc, input logic [31:0] pcnext);
        exp_t e;
        e.pc = pc; e.inst = mem_f(pc); e.pcnext = pcnext; e.adel = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: an instruction is consumed when presented and not stalled by ID.
    always @(negedge clk) begin
        if (!rst && !IF_stall && !ID_stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery actual_pc=%h required=none", IF_PC);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", IF_PC, e.pc);
                chk("sb_inst", IF_inst, e.inst);
                chk("sb_pcnext", IF_PCnext, e.pcnext);
`ifdef IF_ALIGN_CHK_EN
                chk("sb_adel", {31'b0, IF_adel}, {31'b0, e.adel});
`endif
            end
        end
    end

    // Handshake protocol: once req waits without ack, the next cycle keeps req and addr.
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    always @(negedge clk) begin
        if (!rst && prev_wait) begin
            chk("proto_req_held", {31'b0, imem.req}, 32'h1);
            chk("proto_addr_stable", imem.addr, prev_addr);
        end
        prev_wait = !rst && imem.req && !imem.ack;
        prev_addr = imem.addr;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_stall"}, {31'b0, IF_stall}, 32'h1);
        chk({name, "_inst0"}, IF_inst, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ID_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 0;

        // Reset state
        cyc(); @(negedge clk);
        chk("rst_req", {31'b0, imem.req}, 32'h0);
        chk_bubble("rst");
        chk("rst_pc", IF_PC, 32'hBFC00000);
        chk("rst_pcnext", IF_PCnext, 32'hBFC00004);
`ifdef IF_ALIGN_CHK_EN
        chk("rst_adel", {31'b0, IF_adel}, 32'h0);
`endif

        // Zero-wait fetches
        cyc(); rst = 1'b0; push(32'hBFC00000, 32'hBFC00004);
        @(negedge clk);
        chk("zw_addr0", imem.addr, 32'hBFC00000);
        chk("zw_req0", {31'b0, imem.req}, 32'h1);
        chk("zw_stall0", {31'b0, IF_stall}, 32'h0);

        // ID_stall on the BFC00004 ack, three cycles total
        cyc(); ID_stall = 1'b1;
        @(negedge clk);
        chk("zw_addr1", imem.addr, 32'hBFC00004);
        chk("st_pc_ack", IF_PC, 32'hBFC00004);
        for (int i = 0; i < 2; i++) begin
            cyc(); @(negedge clk);
            chk("hold_req", {31'b0, imem.req}, 32'h0);
            chk("hold_pc", IF_PC, 32'hBFC00004);
            chk("hold_inst", IF_inst, mem_f(32'hBFC00004));
            chk("hold_stall", {31'b0, IF_stall}, 32'h0);
        end
        cyc(); ID_stall = 1'b0; push(32'hBFC00004, 32'hBFC00008);
        @(negedge clk);
        chk("rel_pc", IF_PC, 32'hBFC00004);

        // Redirect while a 3-cycle request to BFC00008 is pending
        cyc(); lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h80000100;
        @(negedge clk);
        chk("drop_addr0", imem.addr, 32'hBFC00008);
        chk_bubble("drop0");
        cyc(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("drop_addr1", imem.addr, 32'hBFC00008);
        cyc(); @(negedge clk);
        chk("drop_addr2", imem.addr, 32'hBFC00008);
        cyc(); @(negedge clk);
        chk("drop_ack", {31'b0, imem.ack}, 32'h1);
        chk("drop_addr3", imem.addr, 32'hBFC00008);
        chk_bubble("drop_ackcyc");
        cyc(); lat = 0; push(32'h80000100, 32'h80000104);
        @(negedge clk);
        chk("redir_addr", imem.addr, 32'h80000100);

        // Redirect and ack in the same cycle
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h00001000;
        @(negedge clk);
        chk("rack_addr", imem.addr, 32'h80000104);
        chk_bubble("rack");

        // Redirect in HOLD with ID_stall=1
        cyc(); redirect_valid = 1'b0; ID_stall = 1'b1;
        @(negedge clk);
        chk("rh_addr", imem.addr, 32'h00001000);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h00002000;
        @(negedge clk);
        chk("rh_req", {31'b0, imem.req}, 32'h0);
        chk_bubble("rh");
        cyc(); redirect_valid = 1'b0; ID_stall = 1'b0; push(32'h00002000, 32'h00002004);
        @(negedge clk);
        chk("rh_next_addr", imem.addr, 32'h00002000);

        // Wrap at FFFFFFFC
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        @(negedge clk);
        chk_bubble("wrap_redir");
        cyc(); redirect_valid = 1'b0; push(32'hFFFFFFFC, 32'h00000000);
        @(negedge clk);
        chk("wrap_addr", imem.addr, 32'hFFFFFFFC);
        chk("wrap_pcnext", IF_PCnext, 32'h00000000);
        cyc(); push(32'h00000000, 32'h00000004);
        @(negedge clk);
        chk("wrap_next_addr", imem.addr, 32'h00000000);

        // Reset mid-request
        cyc(); lat = 3;
        @(negedge clk);
        chk("mr_addr", imem.addr, 32'h00000004);
        chk("mr_req", {31'b0, imem.req}, 32'h1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("mr_rst_req", {31'b0, imem.req}, 32'h0);
        chk_bubble("mr_rst");
        chk("mr_rst_pc", IF_PC, 32'hBFC00000);
        cyc(); rst = 1'b0; lat = 0; push(32'hBFC00000, 32'hBFC00004);
        @(negedge clk);
        chk("mr_after_addr", imem.addr, 32'hBFC00000);

        // Reset mid-HOLD
        cyc(); ID_stall = 1'b1;
        @(negedge clk);
        chk("mh_pc", IF_PC, 32'hBFC00004);
        cyc(); @(negedge clk);
        chk("mh_hold_req", {31'b0, imem.req}, 32'h0);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("mh_rst_req", {31'b0, imem.req}, 32'h0);
        chk_bubble("mh_rst");
        chk("mh_rst_pc", IF_PC, 32'hBFC00000);
        cyc(); rst = 1'b0; ID_stall = 1'b0; push(32'hBFC00000, 32'hBFC00004);
        @(negedge clk);
        chk("mh_after_addr", imem.addr, 32'hBFC00000);

`ifdef IF_ALIGN_CHK_EN
        // Misaligned redirect target reports IF_adel without a request
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h80000102;
        @(negedge clk);
        chk_bubble("al_redir");
        cyc(); redirect_valid = 1'b0; ID_stall = 1'b1;
        @(negedge clk);
        chk("al_req", {31'b0, imem.req}, 32'h0);
        chk("al_adel", {31'b0, IF_adel}, 32'h1);
        chk("al_stall", {31'b0, IF_stall}, 32'h0);
        chk("al_pc", IF_PC, 32'h80000102);
        chk("al_inst", IF_inst, 32'h0);
        cyc(); ID_stall = 1'b0;
        begin
            exp_t e;
            e.pc = 32'h80000102; e.inst = 32'h0; e.pcnext = 32'h80000106; e.adel = 1'b1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("al_hold_adel", {31'b0, IF_adel}, 32'h1);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h80000200;
        @(negedge clk);
        chk_bubble("al_drop");
        cyc(); redirect_valid = 1'b0; push(32'h80000200, 32'h80000204);
        @(negedge clk);
        chk("al_next_addr", imem.addr, 32'h80000200);
        chk("al_clear", {31'b0, IF_adel}, 32'h0);
`endif

        cyc(); rst = 1'b1;
        cyc(); cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
